// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready producers.
// Optional packet-lock mode (req_last port, IDLE/LOCKED FSM) is enabled by FIFO_ARB_LOCK_EN.
module fifo_wr_arbiter #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned N     = 4,
    localparam int unsigned IDW   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*WIDTH-1:0]   req_data,
`ifdef FIFO_ARB_LOCK_EN
    input  logic [N-1:0]         req_last,
`endif
    output logic [N-1:0]         req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [WIDTH-1:0]     fifo_wr_data,
    output logic [IDW-1:0]       last_id,
    output logic [15:0]          wr_count
);

`ifdef FIFO_ARB_LOCK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
`endif

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] last_id_q, last_id_d;
    logic [15:0]    wr_count_q, wr_count_d;

    logic [N-1:0]   elig_c;
    logic           found_c;
    logic [IDW-1:0] win_c;
    logic           grant_c;
    logic [IDW-1:0] sel_c;
    logic [IDW-1:0] nxt_c;

    // Rotated-priority scan starting at ptr; a locked packet narrows eligibility to its owner.
    always_comb begin
        elig_c  = req_valid;
`ifdef FIFO_ARB_LOCK_EN
        if (state_q == ST_LOCKED) begin
            elig_c = req_valid & (N'(1) << owner_q);
        end
`endif
        found_c = 1'b0;
        win_c   = '0;
        for (int i = 0; i < int'(N); i++) begin
            int             j;
            logic [IDW-1:0] cand;
            j = int'(ptr_q) + i;
            if (j >= int'(N)) begin
                j = j - int'(N);
            end
            cand = IDW'(j);
            if (!found_c && elig_c[cand]) begin
                found_c = 1'b1;
                win_c   = cand;
            end
        end
        grant_c = rst && !fifo_full && found_c;
        nxt_c   = (win_c == IDW'(N - 1)) ? '0 : win_c + IDW'(1);
    end

    // Handshake and write-port drive; data follows ptr when idle.
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = grant_c;
        fifo_wr_data = '0;
        sel_c        = grant_c ? win_c : ptr_q;
        if (grant_c) begin
            req_ready[win_c] = 1'b1;
        end
        for (int i = 0; i < int'(N); i++) begin
            if (IDW'(i) == sel_c) begin
                fifo_wr_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: registers move only on an accepted beat.
    always_comb begin
        ptr_d      = ptr_q;
        last_id_d  = last_id_q;
        wr_count_d = wr_count_q;
`ifdef FIFO_ARB_LOCK_EN
        state_d    = state_q;
        owner_d    = owner_q;
`endif
        if (grant_c) begin
            last_id_d  = win_c;
            wr_count_d = wr_count_q + 16'd1;
`ifdef FIFO_ARB_LOCK_EN
            case (state_q)
                ST_IDLE: begin
                    if (req_last[win_c]) begin
                        ptr_d = nxt_c;
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = win_c;
                    end
                end
                ST_LOCKED: begin
                    // Packet ends: release and rotate past the owner.
                    if (req_last[win_c]) begin
                        state_d = ST_IDLE;
                        ptr_d   = nxt_c;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
`else
            ptr_d = nxt_c;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            last_id_q  <= '0;
            wr_count_q <= '0;
`ifdef FIFO_ARB_LOCK_EN
            state_q    <= ST_IDLE;
            owner_q    <= '0;
`endif
        end else begin
            ptr_q      <= ptr_d;
            last_id_q  <= last_id_d;
            wr_count_q <= wr_count_d;
`ifdef FIFO_ARB_LOCK_EN
            state_q    <= state_d;
            owner_q    <= owner_d;
`endif
        end
    end

    assign last_id  = last_id_q;
    assign wr_count = wr_count_q;

endmodule
